// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Processes one input bit per clock. A conversion is requested with start
//   while ready=1. The result appears WIDTH edges after the accepting edge,
//   together with a one-cycle valid pulse. The result is then held until the
//   next valid pulse.
//
// Parameters
//   WIDTH    binary input width in bits (>= 2)
//   DIGITS   number of BCD output digits; bcd_out is 4*DIGITS bits wide
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request, sampled only while ready=1
//   bin_in    in   value to convert, captured on the accepting edge
//   ready     out  1 while idle and able to accept start
//   valid     out  one-cycle pulse: bcd_out/overflow/neg were just updated
//   bcd_out   out  result; digit 0 is in [3:0]
//   overflow  out  the result did not fit in DIGITS digits; bcd_out holds
//                  the low-order digits
//   neg       out  sign of the input (signed build only, else constant 0)
//
// Build option
//   SIGNED_INPUT_EN  when defined, bin_in is two's complement. The magnitude
//                    is converted and the sign is reported on neg. When
//                    undefined, no negation logic is built.
// ----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  neg
);

    localparam int                BCD_W      = 4 * DIGITS;
    localparam int                CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [CNT_W-1:0]   count;
    logic               ovf_sticky;

    logic [WIDTH-1:0]   bin_mag;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [WIDTH-1:0]   bin_shifted;
    logic               shift_carry;
    logic [CNT_W-1:0]   count_next;
    logic               accept;
    logic               last_shift;

    // ------------------------------------------------------------------
    // Input magnitude
    // ------------------------------------------------------------------
`ifdef SIGNED_INPUT_EN
    // The most-negative input negates to itself. Read as unsigned, that is
    // exactly +2^(WIDTH-1), so no extra bit is needed.
    assign bin_mag = bin_in[WIDTH-1] ? WIDTH'(-bin_in) : bin_in;
`else
    assign bin_mag = bin_in;
`endif

    // ------------------------------------------------------------------
    // One double-dabble step: add 3 to every digit >= 5, then shift
    // {bcd, bin} left by one. The bit leaving the top digit is the carry
    // into a digit that does not exist, which is what overflow means.
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb block gets a default
    // value first. Otherwise some path leaves it unassigned and a latch is
    // inferred.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {shift_carry, bcd_shifted, bin_shifted} = {bcd_adj, bin_sr, 1'b0};

    assign count_next = count + CNT_W'(1);
    assign accept     = (state == IDLE) && start;
    assign last_shift = (state == SHIFT) && (count_next == LAST_COUNT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments (<=).
    // Every register then samples the values from before the edge, whatever
    // order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)      state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // The handshake outputs come straight from the state register, so
    // there is no combinational path from the inputs to the outputs.
    assign ready = (state == IDLE);
    assign valid = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr     <= '0;
            bcd_sr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            bin_sr     <= bin_mag;
            bcd_sr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else if (state == SHIFT) begin
            bin_sr     <= bin_shifted;
            bcd_sr     <= bcd_shifted;
            count      <= count_next;
            ovf_sticky <= ovf_sticky | shift_carry;
            // The final shift result is taken from the combinational step.
            // That way bcd_out is loaded on the same edge as DONE is entered.
            if (last_shift) begin
                bcd_out  <= bcd_shifted;
                overflow <= ovf_sticky | shift_carry;
            end
        end
    end

`ifdef SIGNED_INPUT_EN
    logic neg_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_cap <= 1'b0;
            neg     <= 1'b0;
        end else begin
            if (accept)     neg_cap <= bin_in[WIDTH-1];
            if (last_shift) neg     <= neg_cap;
        end
    end
`else
    assign neg = 1'b0;
`endif

endmodule
